ram_flip_ctrl: RTL and testbench

// Initiator for the single-port parity RAM: accepts one read/write request at a time on a valid/ready

---
 rtl/ram_flip_pkg.sv | 18 +
 rtl/ram_flip_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_ram_flip_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_flip_pkg.sv
// ram_flip_pkg: constants shared by the parity RAM, its controller and their benches.
//   DEF_* : default geometry and read latency of the single-port parity RAM
//   ST_*  : controller state encodings
package ram_flip_pkg;

   localparam int unsigned DEF_MEM_WIDTH = 16;
   localparam int unsigned DEF_MEM_DEPTH = 1024;
   localparam int unsigned DEF_ADDR_SIZE = 10;
   localparam int unsigned DEF_RD_LAT    = 1;

   localparam int unsigned ST_W = 2;

   localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
   localparam logic [ST_W-1:0] ST_WAIT  = 2'd2;
   localparam logic [ST_W-1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/ram_flip_ctrl.sv
// ram_flip_ctrl: single-outstanding initiator for the single-port parity RAM.
// Takes one request on a valid/ready port, drives the RAM pins for one cycle,
// waits out the read latency and returns data plus parity/address error flags.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake
//   req_wr, req_addr, req_wdata     request payload (1 = write)
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_perr, rsp_aerr   response payload
//   ram_din, ram_addr, ram_wr_en, ram_rd_en, ram_blk_select,
//   ram_addr_en, ram_dout_en        RAM control/data pins (all registered)
//   ram_dout, ram_parity_out        RAM read data and stored even parity
module ram_flip_ctrl
   import ram_flip_pkg::*;
#(
   parameter int unsigned MEM_WIDTH = DEF_MEM_WIDTH,
   parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
   parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
   parameter int unsigned RD_LAT    = DEF_RD_LAT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_wr,
   input  logic [ADDR_SIZE-1:0] req_addr,
   input  logic [MEM_WIDTH-1:0] req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [MEM_WIDTH-1:0] rsp_rdata,
   output logic                 rsp_perr,
   output logic                 rsp_aerr,
   output logic [MEM_WIDTH-1:0] ram_din,
   output logic [ADDR_SIZE-1:0] ram_addr,
   output logic                 ram_wr_en,
   output logic                 ram_rd_en,
   output logic                 ram_blk_select,
   output logic                 ram_addr_en,
   output logic                 ram_dout_en,
   input  logic [MEM_WIDTH-1:0] ram_dout,
   input  logic                 ram_parity_out
);

   localparam int unsigned CNT_W = $clog2(RD_LAT + 1);
   localparam int unsigned AW1   = ADDR_SIZE + 1;
   // Depth widened by one bit so a power-of-two depth equal to 2**ADDR_SIZE still compares correctly
   localparam logic [AW1-1:0] DEPTH_L = AW1'(MEM_DEPTH);

   logic [ST_W-1:0]      r_state,          w_state_nxt;
   logic [CNT_W-1:0]     r_cnt,            w_cnt_nxt;
   logic                 r_wr,             w_wr_nxt;
   logic                 r_req_ready,      w_req_ready_nxt;
   logic                 r_rsp_valid,      w_rsp_valid_nxt;
   logic [MEM_WIDTH-1:0] r_rsp_rdata,      w_rsp_rdata_nxt;
   logic                 r_rsp_perr,       w_rsp_perr_nxt;
   logic                 r_rsp_aerr,       w_rsp_aerr_nxt;
   logic [MEM_WIDTH-1:0] r_ram_din,        w_ram_din_nxt;
   logic [ADDR_SIZE-1:0] r_ram_addr,       w_ram_addr_nxt;
   logic                 r_ram_wr_en,      w_ram_wr_en_nxt;
   logic                 r_ram_rd_en,      w_ram_rd_en_nxt;
   logic                 r_ram_blk_select, w_ram_blk_select_nxt;
   logic                 r_ram_addr_en,    w_ram_addr_en_nxt;
   logic                 r_ram_dout_en,    w_ram_dout_en_nxt;

   logic w_accept;
   logic w_addr_oor;
   logic w_perr;

   assign w_accept   = req_valid & r_req_ready;
   assign w_addr_oor = ({1'b0, req_addr} >= DEPTH_L);
   assign w_perr     = ((^ram_dout) != ram_parity_out);

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= ST_IDLE;
         r_cnt            <= '0;
         r_wr             <= 1'b0;
         r_req_ready      <= 1'b0;
         r_rsp_valid      <= 1'b0;
         r_rsp_rdata      <= '0;
         r_rsp_perr       <= 1'b0;
         r_rsp_aerr       <= 1'b0;
         r_ram_din        <= '0;
         r_ram_addr       <= '0;
         r_ram_wr_en      <= 1'b0;
         r_ram_rd_en      <= 1'b0;
         r_ram_blk_select <= 1'b0;
         r_ram_addr_en    <= 1'b0;
         r_ram_dout_en    <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_cnt            <= w_cnt_nxt;
         r_wr             <= w_wr_nxt;
         r_req_ready      <= w_req_ready_nxt;
         r_rsp_valid      <= w_rsp_valid_nxt;
         r_rsp_rdata      <= w_rsp_rdata_nxt;
         r_rsp_perr       <= w_rsp_perr_nxt;
         r_rsp_aerr       <= w_rsp_aerr_nxt;
         r_ram_din        <= w_ram_din_nxt;
         r_ram_addr       <= w_ram_addr_nxt;
         r_ram_wr_en      <= w_ram_wr_en_nxt;
         r_ram_rd_en      <= w_ram_rd_en_nxt;
         r_ram_blk_select <= w_ram_blk_select_nxt;
         r_ram_addr_en    <= w_ram_addr_en_nxt;
         r_ram_dout_en    <= w_ram_dout_en_nxt;
      end
   end

   // Next state and next registered outputs; outputs are decoded from the state being entered
   always_comb begin
      w_state_nxt          = r_state;
      w_cnt_nxt            = r_cnt;
      w_wr_nxt             = r_wr;
      w_req_ready_nxt      = 1'b0;
      w_rsp_valid_nxt      = 1'b0;
      w_rsp_rdata_nxt      = r_rsp_rdata;
      w_rsp_perr_nxt       = r_rsp_perr;
      w_rsp_aerr_nxt       = r_rsp_aerr;
      w_ram_din_nxt        = r_ram_din;
      w_ram_addr_nxt       = r_ram_addr;
      w_ram_wr_en_nxt      = 1'b0;
      w_ram_rd_en_nxt      = 1'b0;
      w_ram_blk_select_nxt = 1'b0;
      w_ram_addr_en_nxt    = 1'b0;
      w_ram_dout_en_nxt    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_wr_nxt = req_wr;
               if (w_addr_oor) begin
                  // Out-of-range: answer immediately, RAM pins untouched
                  w_state_nxt     = ST_RESP;
                  w_rsp_valid_nxt = 1'b1;
                  w_rsp_rdata_nxt = '0;
                  w_rsp_perr_nxt  = 1'b0;
                  w_rsp_aerr_nxt  = 1'b1;
               end else begin
                  w_state_nxt          = ST_ISSUE;
                  w_ram_blk_select_nxt = 1'b1;
                  w_ram_addr_en_nxt    = 1'b1;
                  w_ram_addr_nxt       = req_addr;
                  w_ram_din_nxt        = req_wdata;
                  w_ram_wr_en_nxt      = req_wr;
                  w_ram_rd_en_nxt      = ~req_wr;
               end
            end else begin
               w_req_ready_nxt = 1'b1;
            end
         end

         ST_ISSUE: begin
            if (r_wr) begin
               w_state_nxt     = ST_RESP;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_rdata_nxt = '0;
               w_rsp_perr_nxt  = 1'b0;
               w_rsp_aerr_nxt  = 1'b0;
            end else begin
               w_state_nxt          = ST_WAIT;
               w_cnt_nxt            = CNT_W'(RD_LAT);
               w_ram_blk_select_nxt = 1'b1;
               w_ram_dout_en_nxt    = 1'b1;
            end
         end

         ST_WAIT: begin
            if (r_cnt == CNT_W'(1)) begin
               // Last latency cycle: RAM output is valid now
               w_state_nxt     = ST_RESP;
               w_cnt_nxt       = '0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_rdata_nxt = ram_dout;
               w_rsp_perr_nxt  = w_perr;
               w_rsp_aerr_nxt  = 1'b0;
            end else begin
               w_cnt_nxt            = r_cnt - CNT_W'(1);
               w_ram_blk_select_nxt = 1'b1;
               w_ram_dout_en_nxt    = 1'b1;
            end
         end

         ST_RESP: begin
            if (rsp_ready) begin
               w_state_nxt     = ST_IDLE;
               w_req_ready_nxt = 1'b1;
            end else begin
               w_rsp_valid_nxt = 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign req_ready      = r_req_ready;
   assign rsp_valid      = r_rsp_valid;
   assign rsp_rdata      = r_rsp_rdata;
   assign rsp_perr       = r_rsp_perr;
   assign rsp_aerr       = r_rsp_aerr;
   assign ram_din        = r_ram_din;
   assign ram_addr       = r_ram_addr;
   assign ram_wr_en      = r_ram_wr_en;
   assign ram_rd_en      = r_ram_rd_en;
   assign ram_blk_select = r_ram_blk_select;
   assign ram_addr_en    = r_ram_addr_en;
   assign ram_dout_en    = r_ram_dout_en;

endmodule

// File: tb/tb_ram_flip_ctrl.sv
// tb_ram_flip_ctrl: bench for ram_flip_ctrl with a behavioural parity RAM (read latency 1)
// and a word-array scoreboard; a second controller with a 512-word depth covers address errors.
module tb_ram_flip_ctrl;

   localparam int unsigned MW     = 16;
   localparam int unsigned AW     = 10;
   localparam int unsigned DEPTH  = 1024;
   localparam int unsigned DEPTH2 = 512;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Main controller signals
   logic          req_valid, req_ready, req_wr;
   logic [AW-1:0] req_addr;
   logic [MW-1:0] req_wdata;
   logic          rsp_valid, rsp_ready, rsp_perr, rsp_aerr;
   logic [MW-1:0] rsp_rdata;
   logic [MW-1:0] ram_din, ram_dout;
   logic [AW-1:0] ram_addr;
   logic          ram_wr_en, ram_rd_en, ram_blk_select, ram_addr_en, ram_dout_en;
   logic          ram_parity_out;

   // Reduced-depth controller signals
   logic          req_valid2, req_ready2, req_wr2;
   logic [AW-1:0] req_addr2;
   logic [MW-1:0] req_wdata2;
   logic          rsp_valid2, rsp_ready2, rsp_perr2, rsp_aerr2;
   logic [MW-1:0] rsp_rdata2;
   logic [MW-1:0] ram_din2;
   logic [AW-1:0] ram_addr2;
   logic          ram_wr_en2, ram_rd_en2, ram_blk_select2, ram_addr_en2, ram_dout_en2;

   int checks = 0;
   int errors = 0;

   ram_flip_ctrl #(.MEM_WIDTH(MW), .MEM_DEPTH(DEPTH), .ADDR_SIZE(AW), .RD_LAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_perr(rsp_perr), .rsp_aerr(rsp_aerr),
      .ram_din(ram_din), .ram_addr(ram_addr), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
      .ram_blk_select(ram_blk_select), .ram_addr_en(ram_addr_en), .ram_dout_en(ram_dout_en),
      .ram_dout(ram_dout), .ram_parity_out(ram_parity_out)
   );

   ram_flip_ctrl #(.MEM_WIDTH(MW), .MEM_DEPTH(DEPTH2), .ADDR_SIZE(AW), .RD_LAT(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid2), .req_ready(req_ready2), .req_wr(req_wr2),
      .req_addr(req_addr2), .req_wdata(req_wdata2),
      .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_rdata(rsp_rdata2),
      .rsp_perr(rsp_perr2), .rsp_aerr(rsp_aerr2),
      .ram_din(ram_din2), .ram_addr(ram_addr2), .ram_wr_en(ram_wr_en2), .ram_rd_en(ram_rd_en2),
      .ram_blk_select(ram_blk_select2), .ram_addr_en(ram_addr_en2), .ram_dout_en(ram_dout_en2),
      .ram_dout(16'h0000), .ram_parity_out(1'b0)
   );

   // Behavioural single-port parity RAM: dout valid the cycle after the rd_en edge
   logic [MW-1:0] ram_mem [DEPTH];
   logic          ram_par_raw;
   logic          inv_par;
   assign ram_parity_out = ram_par_raw ^ inv_par;

   always @(posedge clk) begin
      if (ram_blk_select && ram_addr_en) begin
         if (ram_wr_en) ram_mem[ram_addr] <= ram_din;
         if (ram_rd_en) begin
            ram_dout    <= ram_mem[ram_addr];
            ram_par_raw <= ^ram_mem[ram_addr];
         end
      end
   end

   // Scoreboard: expected memory contents
   logic [MW-1:0] model [DEPTH];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Pin-level invariants checked every cycle out of reset
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("wr_rd_exclusive", 32'(ram_wr_en & ram_rd_en), 32'd0);
         chk("dut2_blk_never", 32'(ram_blk_select2), 32'd0);
      end
   end

   // One request/response on the main controller; returns observed response and latency
   task automatic txn(input logic wr, input logic [AW-1:0] addr, input logic [MW-1:0] wd,
                      input int hold, output logic [MW-1:0] rd, output logic perr,
                      output logic aerr, output int lat);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("req_ready_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      // Now in the issue cycle
      chk("issue_blk", 32'(ram_blk_select), 32'd1);
      chk("issue_wr_en", 32'(ram_wr_en), 32'(wr));
      chk("issue_addr", 32'(ram_addr), 32'(addr));
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
      rd = rsp_rdata; perr = rsp_perr; aerr = rsp_aerr;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_rdata", 32'(rsp_rdata), 32'(rd));
         chk("hold_perr", 32'(rsp_perr), 32'(perr));
         chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_released", 32'(rsp_valid), 32'd0);
   endtask

   // Transaction checked against the scoreboard
   task automatic do_op(input logic wr, input logic [AW-1:0] addr, input logic [MW-1:0] wd,
                        input int hold);
      logic [MW-1:0] rd;
      logic          perr, aerr;
      int            lat;
      logic [MW-1:0] exp_rd;
      logic          exp_perr;
      int            exp_lat;
      if (wr) begin
         model[addr] = wd;
         exp_rd = '0; exp_perr = 1'b0; exp_lat = 2;
      end else begin
         exp_rd = model[addr]; exp_perr = inv_par; exp_lat = 3;
      end
      txn(wr, addr, wd, hold, rd, perr, aerr, lat);
      chk(wr ? "wr_rdata" : "rd_rdata", 32'(rd), 32'(exp_rd));
      chk("perr", 32'(perr), 32'(exp_perr));
      chk("aerr", 32'(aerr), 32'd0);
      chk(wr ? "wr_latency" : "rd_latency", 32'(lat), 32'(exp_lat));
   endtask

   // Out-of-range request on the 512-word controller
   task automatic aerr_op(input logic [AW-1:0] addr);
      req_valid2 = 1'b1; req_wr2 = 1'b0; req_addr2 = addr; req_wdata2 = 16'hFFFF;
      @(posedge clk); #1;
      req_valid2 = 1'b0;
      chk("aerr_valid_lat1", 32'(rsp_valid2), 32'd1);
      chk("aerr_flag", 32'(rsp_aerr2), 32'd1);
      chk("aerr_rdata", 32'(rsp_rdata2), 32'd0);
      chk("aerr_req_ready", 32'(req_ready2), 32'd0);
      rsp_ready2 = 1'b1;
      @(posedge clk); #1;
      rsp_ready2 = 1'b0;
      chk("aerr_released", 32'(rsp_valid2), 32'd0);
      @(posedge clk); #1;
      chk("aerr_ready_back", 32'(req_ready2), 32'd1);
   endtask

   initial begin
      logic [MW-1:0] v;
      req_valid = 0; req_wr = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
      req_valid2 = 0; req_wr2 = 0; req_addr2 = '0; req_wdata2 = '0; rsp_ready2 = 0;
      inv_par = 0; ram_dout = '0; ram_par_raw = 0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         v = MW'($urandom);
         ram_mem[i] = v;
         model[i]   = v;
      end

      // Reset state
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_blk", 32'(ram_blk_select), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      #20 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);

      // Write then read back
      do_op(1'b1, 10'd5, 16'hA5A5, 0);
      do_op(1'b0, 10'd5, 16'h0000, 0);

      // Top address with stalled consumer
      do_op(1'b0, 10'd1023, 16'h0000, 4);

      // Parity error injection on a read of 16'h0001
      do_op(1'b1, 10'd9, 16'h0001, 0);
      inv_par = 1'b1;
      do_op(1'b0, 10'd9, 16'h0000, 1);
      inv_par = 1'b0;
      do_op(1'b0, 10'd9, 16'h0000, 0);

      // Address range checks on the reduced-depth controller
      aerr_op(10'd600);
      aerr_op(10'd512);
      aerr_op(10'd1023);

      // Reset during the read wait
      while (req_ready !== 1'b1) begin @(posedge clk); #1; end
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'd7;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("wait_dout_en", 32'(ram_dout_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_req_ready", 32'(req_ready), 32'd0);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_blk", 32'(ram_blk_select), 32'd0);
      chk("midrst_dout_en", 32'(ram_dout_en), 32'd0);
      chk("midrst_addr", 32'(ram_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("after_rst_req_ready", 32'(req_ready), 32'd1);
      chk("after_rst_no_rsp", 32'(rsp_valid), 32'd0);

      // Randomized traffic against the scoreboard
      for (int k = 0; k < 200; k++) begin
         do_op(1'($urandom), AW'($urandom_range(0, DEPTH - 1)), MW'($urandom),
               int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
